// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the IMEM loader: FSM state encoding, data widths, checksum step.
// Optional checksum trailer is enabled with the CHECKSUM_EN macro.
package imem_loader_pkg;

  localparam int XLEN   = 32;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_HDR0 = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] sum,
                                                 input logic [BYTE_W-1:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and IMEM write port of the loader, bundled with host/loader modports.
interface imem_loader_if #(parameter int ADDR_W = 10);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (output in_data, output in_valid, input in_ready,
                  input imem_we, input imem_addr, input imem_wdata);

  modport slave  (input in_data, input in_valid, output in_ready,
                  output imem_we, output imem_addr, output imem_wdata);

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs four stream bytes LSB-first into a word; word_valid marks the cycle the 4th byte is taken.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              take,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              word_valid,
  output logic [XLEN-1:0]   word
);

  logic [1:0]             idx_r;
  logic [XLEN-BYTE_W-1:0] shift_r;

  assign word_valid = take && (idx_r == 2'd3);
  assign word       = {in_byte, shift_r};

  // byte index and the three bytes already received for the current word
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx_r   <= 2'd0;
      shift_r <= '0;
    end else if (take) begin
      idx_r   <= idx_r + 2'd1;
      shift_r <= {in_byte, shift_r[XLEN-BYTE_W-1:BYTE_W]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// IMEM writer: takes a count-prefixed little-endian word stream and fills IMEM from address 0,
// holding the core in reset until done. Define CHECKSUM_EN for a trailing 8-bit checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          core_rst,
  output logic          done,
  output logic          err,
  imem_loader_if.slave  bus
);

`ifdef CHECKSUM_EN
  localparam state_e ST_TAIL = ST_CHK;
  logic [BYTE_W-1:0] sum_r;
`else
  localparam state_e ST_TAIL = ST_DONE;
`endif

  state_e            state_r, next_s;
  logic [CNT_W-1:0]  count_r, cnt_full_s, word_idx_r;
  logic              take_s, restart_s, last_s, done_nxt_s;
  logic              word_valid_s;
  logic [XLEN-1:0]   word_s;
  logic              in_ready_r, imem_we_r, core_rst_r, done_r, err_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [XLEN-1:0]   imem_wdata_r;

  assign take_s     = bus.in_valid && in_ready_r;
  assign restart_s  = start && ((state_r == ST_DONE) || (state_r == ST_ERR));
  assign cnt_full_s = {bus.in_data, count_r[BYTE_W-1:0]};
  assign last_s     = (word_idx_r == (count_r - 16'd1));
  // done is raised one cycle after the state lands in DONE, so it trails the last write pulse
  assign done_nxt_s = (state_r == ST_DONE) && (next_s == ST_DONE);

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (restart_s),
    .take       (take_s && (state_r == ST_DATA)),
    .in_byte    (bus.in_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_HDR0: begin
        if (take_s) next_s = ST_HDR1;
        else        next_s = state_r;
      end
      ST_HDR1: begin
        if (!take_s)                           next_s = state_r;
        else if (cnt_full_s > 16'(MAX_WORDS))  next_s = ST_ERR;
        else if (cnt_full_s == 16'd0)          next_s = ST_TAIL;
        else                                   next_s = ST_DATA;
      end
      ST_DATA: begin
        if (word_valid_s && last_s) next_s = ST_TAIL;
        else                        next_s = state_r;
      end
`ifdef CHECKSUM_EN
      ST_CHK: begin
        if (!take_s)                                    next_s = state_r;
        else if (csum_add(sum_r, bus.in_data) == 8'd0)  next_s = ST_DONE;
        else                                            next_s = ST_ERR;
      end
`endif
      ST_DONE, ST_ERR: begin
        if (start) next_s = ST_HDR0;
        else       next_s = state_r;
      end
      default: next_s = ST_ERR;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_HDR0;
    else     state_r <= next_s;
  end

  // header count, word index, IMEM write port and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r      <= 16'd0;
      word_idx_r   <= 16'd0;
      in_ready_r   <= 1'b1;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'd0;
      core_rst_r   <= 1'b1;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      in_ready_r <= !((next_s == ST_DONE) || (next_s == ST_ERR));
      done_r     <= done_nxt_s;
      core_rst_r <= !done_nxt_s;
      err_r      <= (next_s == ST_ERR);
      imem_we_r  <= word_valid_s;
      if (take_s && (state_r == ST_HDR0)) count_r[7:0]  <= bus.in_data;
      if (take_s && (state_r == ST_HDR1)) count_r[15:8] <= bus.in_data;
      if (restart_s) begin
        word_idx_r <= 16'd0;
      end else if (word_valid_s) begin
        imem_addr_r  <= word_idx_r[ADDR_W-1:0];
        imem_wdata_r <= word_s;
        word_idx_r   <= word_idx_r + 16'd1;
      end
    end
  end

`ifdef CHECKSUM_EN
  // running sum of DATA bytes
  always_ff @(posedge clk) begin
    if (rst || restart_s)                    sum_r <= 8'd0;
    else if (take_s && (state_r == ST_DATA)) sum_r <= csum_add(sum_r, bus.in_data);
  end
`endif

  assign bus.in_ready   = in_ready_r;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign core_rst       = core_rst_r;
  assign done           = done_r;
  assign err            = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads plus randomized words/gaps compared
// against the expected IMEM image built from the stream format.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst, start;
  logic core_rst, done, err;
  int   checks = 0;
  int   errors = 0;

  logic [9:0]  got_a[$];
  logic [31:0] got_d[$];
  logic [31:0] words_q[$];

  imem_loader_if #(.ADDR_W(10)) bus ();

  imem_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .core_rst (core_rst),
    .done     (done),
    .err      (err),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      got_a.push_back(bus.imem_addr);
      got_d.push_back(bus.imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    start = 1'b0;
    bus.in_data = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic idle_cycle(input bit poke_start);
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = poke_start;
  endtask

  task automatic restart();
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_core_rst", {63'd0, core_rst}, 64'd1);
    chk("restart_done", {63'd0, done}, 64'd0);
    chk("restart_err", {63'd0, err}, 64'd0);
    chk("restart_ready", {63'd0, bus.in_ready}, 64'd1);
  endtask

  // Streams words_q (count header, LSB-first bytes, optional checksum) and checks the image.
  task automatic run_load(input int gap_pct, input bit poke_start, input bit bad_chk);
    int          n = words_q.size();
    logic [15:0] cnt = 16'(n);
    logic [7:0]  sum = 8'd0;
    logic [31:0] w;
    logic [7:0]  b;
    bit          expect_err = 1'b0;
    got_a.delete();
    got_d.delete();
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
    for (int i = 0; i < n; i++) begin
      w = words_q[i];
      for (int k = 0; k < 4; k++) begin
        if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) idle_cycle(poke_start);
        b = w[8*k +: 8];
        sum = sum + b;
        send_byte(b);
      end
    end
`ifdef CHECKSUM_EN
    b = 8'd0 - sum;
    if (bad_chk) b = b + 8'd1;
    expect_err = bad_chk;
    send_byte(b);
`endif
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("done_not_early", {63'd0, done}, 64'd0);
`ifndef CHECKSUM_EN
    chk("last_we", {63'd0, bus.imem_we}, {63'd0, (n > 0)});
`endif
    @(negedge clk);
    chk("final_done", {63'd0, done}, {63'd0, !expect_err});
    chk("final_err", {63'd0, err}, {63'd0, expect_err});
    chk("final_core_rst", {63'd0, core_rst}, {63'd0, expect_err});
    chk("final_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("write_count", 64'(got_a.size()), 64'(n));
    for (int i = 0; i < n && i < got_a.size(); i++) begin
      chk("write_addr", {54'd0, got_a[i]}, 64'(i));
      chk("write_data", {32'd0, got_d[i]}, {32'd0, words_q[i]});
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_we", {63'd0, bus.imem_we}, 64'd0);
    chk("rst_addr", {54'd0, bus.imem_addr}, 64'd0);
    chk("rst_wdata", {32'd0, bus.imem_wdata}, 64'd0);
    chk("rst_core_rst", {63'd0, core_rst}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    rst = 1'b0;

    // two-instruction program
    words_q = '{32'h00A00513, 32'h00100593};
    run_load(0, 1'b0, 1'b0);
    restart();

    // oversize count aborts without writing
    got_a.delete();
    send_byte(8'h01);
    send_byte(8'h04);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("ovf_err", {63'd0, err}, 64'd1);
    chk("ovf_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("ovf_core_rst", {63'd0, core_rst}, 64'd1);
    repeat (3) @(negedge clk);
    chk("ovf_no_write", 64'(got_a.size()), 64'd0);
    chk("ovf_done", {63'd0, done}, 64'd0);
    restart();

    // empty program
    words_q.delete();
    run_load(0, 1'b0, 1'b0);
    restart();

`ifdef CHECKSUM_EN
    words_q = '{32'h04030201};
    run_load(0, 1'b0, 1'b0);
    restart();
    run_load(0, 1'b0, 1'b1);
    restart();
`endif

    // reset mid-word discards the partial word
    got_a.delete();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_we", {63'd0, bus.imem_we}, 64'd0);
    chk("midrst_no_write", 64'(got_a.size()), 64'd0);
    chk("midrst_core_rst", {63'd0, core_rst}, 64'd1);
    words_q = '{32'hDEADBEEF};
    run_load(0, 1'b0, 1'b0);

    // random programs with stalls and ignored start pulses
    for (int r = 0; r < 4; r++) begin
      restart();
      words_q.delete();
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) words_q.push_back($urandom);
      run_load(50, 1'b1, 1'b0);
    end

    // largest accepted program fills every address
    restart();
    words_q.delete();
    for (int i = 0; i < 1024; i++) words_q.push_back($urandom);
    run_load(0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
